// File: rtl/video_capture_if.sv
// Capture-buffer write port: wr_addr/wr_data qualified by wr_valid, accepted on wr_ready.
interface video_capture_if #(
  parameter int ADDR_W = 13
) ();
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_addr, output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_addr, input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/video_capture.sv
// Raster capture: samples serial pixels, packs 8 per byte (MSB first) and writes to a buffer.
// Optional VIDEO_CAPTURE_STATS_EN adds h_period/v_period sync-period measurement outputs.
module video_capture #(
  parameter int COLS    = 40,
  parameter int ROWS    = 200,
  parameter int H_START = 128,
  parameter int V_START = 40,
  parameter int ADDR_W  = 13
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic enable,
  input  logic video_in,
  input  logic h_sync_in,
  input  logic v_sync_in,
  video_capture_if.master wr,
  output logic frame_done,
  output logic overflow,
  output logic timing_err
`ifdef VIDEO_CAPTURE_STATS_EN
  ,
  output logic [9:0] h_period,
  output logic [9:0] v_period
`endif
);
  localparam int PIX    = COLS * 8;
  localparam int PCNT_N = (H_START > PIX) ? H_START : PIX;
  localparam int LCNT_N = (V_START > ROWS) ? V_START : ROWS;
  localparam int PCNT_W = $clog2(PCNT_N);
  localparam int LCNT_W = (LCNT_N > 1) ? $clog2(LCNT_N) : 1;
  localparam logic [LCNT_W-1:0] LAST_ROW = LCNT_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, VWAIT, HWAIT, SHIFT} state_t;

  state_t            state, state_next;
  logic [PCNT_W-1:0] pcnt, pcnt_next;
  logic [LCNT_W-1:0] lcnt, lcnt_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [6:0]        shreg;
  logic              h_prev, v_prev, h_rise, v_rise;
  logic              last_pend;
  logic              clr_sticky, set_terr, sample, byte_done, frame_end;

  assign h_rise = h_sync_in & ~h_prev;
  assign v_rise = v_sync_in & ~v_prev;

  always_ff @(posedge pixel_clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // In HWAIT, pcnt==0 means "waiting for an h_sync rise"; nonzero counts clocks since it.
  always_comb begin
    state_next = state;
    pcnt_next  = pcnt;
    lcnt_next  = lcnt;
    base_next  = base;
    clr_sticky = 1'b0;
    set_terr   = 1'b0;
    sample     = 1'b0;
    byte_done  = 1'b0;
    frame_end  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (v_rise) begin
          state_next = VWAIT;
          clr_sticky = 1'b1;
          pcnt_next  = '0;
          lcnt_next  = '0;
          base_next  = '0;
        end
        VWAIT: if (v_rise) begin
          lcnt_next = '0;
        end else if (h_rise) begin
          if (lcnt == LCNT_W'(V_START - 1)) begin
            state_next = HWAIT;
            lcnt_next  = '0;
            pcnt_next  = PCNT_W'(1);
          end else begin
            lcnt_next = lcnt + 1'b1;
          end
        end
        HWAIT, SHIFT: if (v_rise) begin
          state_next = VWAIT;
          set_terr   = 1'b1;
          pcnt_next  = '0;
          lcnt_next  = '0;
          base_next  = '0;
        end else if (h_rise) begin
          pcnt_next = PCNT_W'(1);
          if (state == SHIFT) begin
            set_terr = 1'b1;
            if (lcnt == LAST_ROW) begin
              state_next = IDLE;
            end else begin
              state_next = HWAIT;
              lcnt_next  = lcnt + 1'b1;
              base_next  = base + ADDR_W'(COLS);
            end
          end
        end else if (state == HWAIT) begin
          if (pcnt == PCNT_W'(H_START - 1)) begin
            state_next = SHIFT;
            pcnt_next  = '0;
          end else if (pcnt != '0) begin
            pcnt_next = pcnt + 1'b1;
          end
        end else begin
          sample    = 1'b1;
          byte_done = (pcnt[2:0] == 3'd7);
          if (pcnt == PCNT_W'(PIX - 1)) begin
            pcnt_next = '0;
            if (lcnt == LAST_ROW) begin
              state_next = IDLE;
              frame_end  = 1'b1;
            end else begin
              state_next = HWAIT;
              lcnt_next  = lcnt + 1'b1;
              base_next  = base + ADDR_W'(COLS);
            end
          end else begin
            pcnt_next = pcnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      pcnt        <= '0;
      lcnt        <= '0;
      base        <= '0;
      shreg       <= '0;
      h_prev      <= 1'b0;
      v_prev      <= 1'b0;
      last_pend   <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      wr.wr_valid <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      pcnt       <= pcnt_next;
      lcnt       <= lcnt_next;
      base       <= base_next;
      h_prev     <= h_sync_in;
      v_prev     <= v_sync_in;
      frame_done <= 1'b0;
      if (sample) shreg <= {shreg[5:0], video_in};
      if (wr.wr_valid && wr.wr_ready) begin
        wr.wr_valid <= 1'b0;
        last_pend   <= 1'b0;
        if (last_pend) frame_done <= 1'b1;
      end
      if (clr_sticky) begin
        overflow   <= 1'b0;
        timing_err <= 1'b0;
      end
      if (set_terr) timing_err <= 1'b1;
      // A dropped byte still consumes its address; the holding register is untouched.
      if (byte_done) begin
        if (wr.wr_valid && !wr.wr_ready) begin
          overflow <= 1'b1;
          if (frame_end) frame_done <= 1'b1;
        end else begin
          wr.wr_valid <= 1'b1;
          wr.wr_addr  <= base + ADDR_W'(pcnt >> 3);
          wr.wr_data  <= {shreg, video_in};
          last_pend   <= frame_end;
        end
      end
    end
  end

`ifdef VIDEO_CAPTURE_STATS_EN
  logic [9:0] h_cnt, v_cnt, v_inc;

  assign v_inc = (h_rise && v_cnt != 10'h3ff) ? v_cnt + 10'd1 : v_cnt;

  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      h_period <= '0;
      v_period <= '0;
    end else begin
      if (h_rise) begin
        h_period <= h_cnt;
        h_cnt    <= 10'd1;
      end else if (h_cnt != 10'h3ff) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (v_rise) begin
        v_period <= v_inc;
        v_cnt    <= '0;
      end else begin
        v_cnt <= v_inc;
      end
    end
  end
`endif
endmodule

// File: tb/tb_video_capture.sv
// Drives a scaled-down raster with random images and checks captured writes against the image.
module tb_video_capture;
  localparam int COLS = 4, ROWS = 6, H_START = 10, V_START = 3, ADDR_W = 6;
  localparam int LL = 64, HS_W = 4, FL = 12, VPOS = 20, NB = COLS * ROWS;

  logic pixel_clk = 1'b0;
  logic reset, enable, video_in, h_sync_in, v_sync_in;
  logic frame_done, overflow, timing_err;
`ifdef VIDEO_CAPTURE_STATS_EN
  logic [9:0] h_period, v_period;
`endif

  video_capture_if #(.ADDR_W(ADDR_W)) wr ();

  video_capture #(
    .COLS(COLS), .ROWS(ROWS), .H_START(H_START), .V_START(V_START), .ADDR_W(ADDR_W)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .enable(enable),
    .video_in(video_in),
    .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in),
    .wr(wr),
    .frame_done(frame_done),
    .overflow(overflow),
    .timing_err(timing_err)
`ifdef VIDEO_CAPTURE_STATS_EN
    ,
    .h_period(h_period),
    .v_period(v_period)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0, errors = 0;
  logic [7:0] img [NB];
  int got_addr[$];
  int got_data[$];
  int fd_cnt = 0;
  bit bp_arm = 1'b0;
  int bp_cnt = 0;

  // Monitor: record every handshake and frame_done pulse.
  always @(negedge pixel_clk) begin
    if (wr.wr_valid === 1'b1 && wr.wr_ready === 1'b1) begin
      got_addr.push_back(int'(wr.wr_addr));
      got_data.push_back(int'(wr.wr_data));
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_image();
    for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
  endtask

  task automatic drive_line(input int len, input int vpos, input int row);
    int c;
    for (int p = 0; p < len; p++) begin
      @(posedge pixel_clk); #1;
      h_sync_in = (p < HS_W);
      v_sync_in = (vpos >= 0) && (p >= vpos) && (p < vpos + 10);
      c = p - H_START;
      if (row >= 0 && c >= 0 && c < COLS * 8) video_in = img[row * COLS + c / 8][7 - c % 8];
      else video_in = 1'($urandom);
      if (bp_arm && wr.wr_valid) begin
        bp_arm = 1'b0;
        bp_cnt = 9;
        wr.wr_ready = 1'b0;
      end else if (bp_cnt > 0) begin
        bp_cnt--;
      end else begin
        wr.wr_ready = 1'b1;
      end
    end
  endtask

  task automatic frame_body(input int trunc_row);
    int row;
    for (int l = 1; l < FL; l++) begin
      row = (l >= V_START && l < V_START + ROWS) ? l - V_START : -1;
      drive_line((row >= 0 && row == trunc_row) ? 30 : LL, -1, row);
    end
  endtask

  // Expected writes: image bytes in address order for nrows rows, minus [dlo,dhi].
  task automatic check_writes(input string tag, input int n0, input int nrows,
                              input int dlo, input int dhi);
    int k, n;
    n = 0;
    for (int a = 0; a < nrows * COLS; a++) if (a < dlo || a > dhi) n++;
    chk({tag, "_count"}, got_addr.size() - n0, n);
    k = n0;
    for (int a = 0; a < nrows * COLS; a++) begin
      if (a < dlo || a > dhi) begin
        if (k < got_addr.size()) begin
          chk({tag, "_addr"}, got_addr[k], a);
          chk({tag, "_data"}, got_data[k], int'(img[a]));
        end
        k++;
      end
    end
  endtask

  initial begin
    int n0, fd0;
    reset = 1'b0; enable = 1'b0; video_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    wr.wr_ready = 1'b1;
    repeat (4) @(posedge pixel_clk);
    #1;
    chk("rst_valid", int'(wr.wr_valid), 0);
    chk("rst_addr", int'(wr.wr_addr), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_timing_err", int'(timing_err), 0);
    reset = 1'b1;
    enable = 1'b1;

    // Two clean frames with full-rate acceptance.
    for (int f = 0; f < 2; f++) begin
      new_image();
      n0 = got_addr.size(); fd0 = fd_cnt;
      drive_line(LL, VPOS, -1);
      frame_body(-1);
      check_writes("clean", n0, ROWS, NB, NB);
      chk("clean_frame_done", fd_cnt - fd0, 1);
      chk("clean_overflow", int'(overflow), 0);
      chk("clean_timing_err", int'(timing_err), 0);
    end
`ifdef VIDEO_CAPTURE_STATS_EN
    chk("h_period", int'(h_period), LL);
    chk("v_period", int'(v_period), FL);
`endif

    // Backpressure: ready low for 10 clocks after the first valid drops byte 1.
    new_image();
    n0 = got_addr.size(); fd0 = fd_cnt;
    bp_arm = 1'b1;
    drive_line(LL, VPOS, -1);
    frame_body(-1);
    check_writes("bp", n0, ROWS, 1, 1);
    chk("bp_frame_done", fd_cnt - fd0, 1);
    chk("bp_overflow", int'(overflow), 1);

    // v_sync rise after three captured lines aborts the frame.
    new_image();
    n0 = got_addr.size(); fd0 = fd_cnt;
    drive_line(LL, VPOS, -1);
    drive_line(LL, -1, -1);
    drive_line(LL, -1, -1);
    drive_line(LL, -1, 0);
    drive_line(LL, -1, 1);
    drive_line(LL, 50, 2);
    check_writes("abort", n0, 3, NB, NB);
    chk("abort_frame_done", fd_cnt - fd0, 0);
    chk("abort_timing_err", int'(timing_err), 1);
    chk("abort_overflow_clr", int'(overflow), 0);
    new_image();
    n0 = got_addr.size(); fd0 = fd_cnt;
    frame_body(-1);
    check_writes("restart", n0, ROWS, NB, NB);
    chk("restart_frame_done", fd_cnt - fd0, 1);
    chk("restart_timing_err", int'(timing_err), 1);

    // h_sync rise mid-line truncates row 1 after its first two bytes.
    new_image();
    n0 = got_addr.size(); fd0 = fd_cnt;
    drive_line(LL, VPOS, -1);
    frame_body(1);
    check_writes("trunc", n0, ROWS, 6, 7);
    chk("trunc_frame_done", fd_cnt - fd0, 1);
    chk("trunc_timing_err", int'(timing_err), 1);

    // Disabled frame, then enable mid-frame: nothing until the next v_sync.
    new_image();
    n0 = got_addr.size(); fd0 = fd_cnt;
    enable = 1'b0;
    drive_line(LL, VPOS, -1);
    frame_body(-1);
    chk("dis_count", got_addr.size() - n0, 0);
    drive_line(LL, VPOS, -1);
    for (int l = 1; l < FL; l++) begin
      if (l == 5) enable = 1'b1;
      drive_line(LL, -1, (l >= V_START && l < V_START + ROWS) ? l - V_START : -1);
    end
    chk("midena_count", got_addr.size() - n0, 0);
    chk("midena_frame_done", fd_cnt - fd0, 0);
    new_image();
    n0 = got_addr.size(); fd0 = fd_cnt;
    drive_line(LL, VPOS, -1);
    frame_body(-1);
    check_writes("ena", n0, ROWS, NB, NB);
    chk("ena_frame_done", fd_cnt - fd0, 1);
    chk("ena_timing_err_clr", int'(timing_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
